vt52_scroll_engine: RTL and testbench

- Wishbone master that performs bulk video-memory operations for the VT52 terminal: scroll up, scroll down, clear to end of line, clear to end of screen.
- Sits directly upstream of the text VGA adapter and drives its 16-bit Wishbone slave port, so the terminal CPU does not move 40 words per row by software.
- Text area is 80 bytes/row; rows 0–1 are service/clock lines and are never touched.

---
 rtl/vt52_pkg.sv | 25 ++
 rtl/vt52_wb_access.sv | 92 +++++++++
 rtl/vt52_scroll_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_vt52_scroll_engine.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt52_pkg.sv
// Shared encodings for the VT52 scroll engine: command opcodes, FSM states, row limits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vt52_pkg;

    localparam logic [1:0] OP_SCROLL_UP = 2'd0;
    localparam logic [1:0] OP_SCROLL_DN = 2'd1;
    localparam logic [1:0] OP_CLR_EOL   = 2'd2;
    localparam logic [1:0] OP_CLR_EOS   = 2'd3;

    localparam int ROWS_24_LAST = 23;
    localparam int ROWS_40_LAST = 39;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_FILL,
        ST_FILL_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vt52_wb_access.sv
// Single-word classic Wishbone master: one req launches one read or write cycle.
// Latency: cyc rises the edge after req; ack_pulse_o is high the cycle after the slave ack.
// Backpressure: busy_o while a cycle is open; req ignored while busy; cyc stays low >= 1 cycle between accesses.
module vt52_wb_access (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  sel_i,
    output logic        busy_o,
    output logic [15:0] rdata_o,
    output logic        ack_pulse_o,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [15:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_pulse_q, ack_pulse_d;

    // Open a cycle on req when idle; close it on the ack edge so cyc is low for at least one cycle
    // before the next access (the slave will not re-ack while its ack is still high).
    always_comb begin
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rdata_d     = rdata_q;
        ack_pulse_d = 1'b0;
        if (cyc_q) begin
            if (wbm_ack_i) begin
                cyc_d       = 1'b0;
                we_d        = 1'b0;
                ack_pulse_d = 1'b1;
                if (!we_q) begin
                    rdata_d = wbm_dat_i;
                end
            end
        end else if (req_i) begin
            cyc_d = 1'b1;
            we_d  = we_i;
            adr_d = {adr_i[15:1], 1'b0};
            dat_d = dat_i;
            sel_d = sel_i;
        end
    end

    // Bus-side registers; reset releases the bus immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= 2'b11;
            rdata_q     <= '0;
            ack_pulse_q <= 1'b0;
        end else begin
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            ack_pulse_q <= ack_pulse_d;
        end
    end

    assign busy_o      = cyc_q;
    assign rdata_o     = rdata_q;
    assign ack_pulse_o = ack_pulse_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;

endmodule

// File: rtl/vt52_scroll_engine.sv
// VT52 bulk video-memory engine: scroll up/down and clear-to-EOL/EOS over a 16-bit Wishbone master.
// Latency: done pulses 2 cycles after accept for no-traffic ops, else 2 cycles after the last write ack.
// Backpressure: cmd_ready only in IDLE; requests while busy are ignored. Scroll down needs VT52_SCROLL_DOWN_EN.
module vt52_scroll_engine
    import vt52_pkg::*;
#(
    parameter int         COLS      = 80,
    parameter int         FIRST_ROW = 2,
    parameter logic [7:0] FILL      = 8'h20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        lmode,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [12:0] cmd_pos,
    output logic        done,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    localparam int          MAX_ROWS  = ROWS_40_LAST + 1;
    localparam logic [12:0] COLS_A    = 13'(COLS);
    localparam logic [12:0] A_FIRST   = 13'(FIRST_ROW * COLS);
    localparam logic [12:0] BASE_L24  = 13'(ROWS_24_LAST * COLS);
    localparam logic [12:0] BASE_L40  = 13'(ROWS_40_LAST * COLS);
    localparam logic [12:0] SCR_END24 = 13'((ROWS_24_LAST + 1) * COLS - 2);
    localparam logic [12:0] SCR_END40 = 13'((ROWS_40_LAST + 1) * COLS - 2);
    localparam logic [12:0] POS_MAX24 = 13'((ROWS_24_LAST + 1) * COLS - 1);
    localparam logic [12:0] POS_MAX40 = 13'((ROWS_40_LAST + 1) * COLS - 1);

    state_t      state_q, state_d;
    logic [12:0] p_q, p_d;                   // current word address (row-relative copy target/fill)
    logic [12:0] copy_end_q, copy_end_d;     // last p of the copy phase
    logic [12:0] fill_start_q, fill_start_d;
    logic [12:0] fill_end_q, fill_end_d;
    logic        odd_q, odd_d;               // next fill write covers only the upper byte
    logic        done_q, done_d;
`ifdef VT52_SCROLL_DOWN_EN
    logic        down_q, down_d;
`endif

    logic [12:0] last_base, scr_end, pos_max, row_end, pos_word;
    logic [12:0] rd_adr, wr_adr, p_step;
    logic        pos_ok;

    logic        acc_req, acc_we, acc_busy, acc_ack;
    logic [15:0] acc_adr, acc_dat, acc_rdata;
    logic [1:0]  acc_sel;

    // Command decode: screen geometry from lmode and the last word of cmd_pos's row via a comparator chain.
    always_comb begin
        last_base = lmode ? BASE_L40 : BASE_L24;
        scr_end   = lmode ? SCR_END40 : SCR_END24;
        pos_max   = lmode ? POS_MAX40 : POS_MAX24;
        pos_ok    = (cmd_pos >= A_FIRST) && (cmd_pos <= pos_max);
        pos_word  = {cmd_pos[12:1], 1'b0};
        row_end   = COLS_A - 13'd2;
        for (int r = 1; r < MAX_ROWS; r++) begin
            if (cmd_pos >= 13'(r * COLS)) begin
                row_end = 13'((r + 1) * COLS - 2);
            end
        end
    end

    // Copy direction: ascending reads come from the row below; descending reads from p, writes go a row down.
    always_comb begin
`ifdef VT52_SCROLL_DOWN_EN
        rd_adr = down_q ? p_q : p_q + COLS_A;
        wr_adr = down_q ? p_q + COLS_A : p_q;
        p_step = down_q ? p_q - 13'd2 : p_q + 13'd2;
`else
        rd_adr = p_q + COLS_A;
        wr_adr = p_q;
        p_step = p_q + 13'd2;
`endif
    end

    // Main sequencer: accept, copy loop, fill loop, done.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        copy_end_d   = copy_end_q;
        fill_start_d = fill_start_q;
        fill_end_d   = fill_end_q;
        odd_d        = odd_q;
        done_d       = (state_q == ST_DONE);
`ifdef VT52_SCROLL_DOWN_EN
        down_d       = down_q;
`endif
        acc_req      = 1'b0;
        acc_we       = 1'b0;
        acc_adr      = 16'h0000;
        acc_dat      = 16'h0000;
        acc_sel      = 2'b11;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    odd_d = 1'b0;
`ifdef VT52_SCROLL_DOWN_EN
                    down_d = 1'b0;
`endif
                    case (cmd_op)
                        OP_SCROLL_UP: begin
                            p_d          = A_FIRST;
                            copy_end_d   = last_base - 13'd2;
                            fill_start_d = last_base;
                            fill_end_d   = scr_end;
                            state_d      = ST_RD;
                        end
                        OP_SCROLL_DN: begin
`ifdef VT52_SCROLL_DOWN_EN
                            down_d       = 1'b1;
                            p_d          = last_base - 13'd2;
                            copy_end_d   = A_FIRST;
                            fill_start_d = A_FIRST;
                            fill_end_d   = A_FIRST + COLS_A - 13'd2;
                            state_d      = ST_RD;
`else
                            state_d      = ST_DONE;
`endif
                        end
                        default: begin
                            if (pos_ok) begin
                                p_d        = pos_word;
                                fill_end_d = (cmd_op == OP_CLR_EOL) ? row_end : scr_end;
                                odd_d      = cmd_pos[0];
                                state_d    = ST_FILL;
                            end else begin
                                state_d    = ST_DONE;
                            end
                        end
                    endcase
                end
            end
            ST_RD: begin
                acc_req = !acc_busy;
                acc_adr = {3'b000, rd_adr};
                if (!acc_busy) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (acc_ack) state_d = ST_WR;
            end
            ST_WR: begin
                acc_req = !acc_busy;
                acc_we  = 1'b1;
                acc_adr = {3'b000, wr_adr};
                acc_dat = acc_rdata;
                if (!acc_busy) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (acc_ack) begin
                    if (p_q == copy_end_q) begin
                        p_d     = fill_start_q;
                        state_d = ST_FILL;
                    end else begin
                        p_d     = p_step;
                        state_d = ST_RD;
                    end
                end
            end
            ST_FILL: begin
                acc_req = !acc_busy;
                acc_we  = 1'b1;
                acc_adr = {3'b000, p_q};
                acc_dat = {FILL, FILL};
                acc_sel = odd_q ? 2'b10 : 2'b11;
                if (!acc_busy) state_d = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (acc_ack) begin
                    odd_d = 1'b0;
                    if (p_q == fill_end_q) begin
                        state_d = ST_DONE;
                    end else begin
                        p_d     = p_q + 13'd2;
                        state_d = ST_FILL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            copy_end_q   <= '0;
            fill_start_q <= '0;
            fill_end_q   <= '0;
            odd_q        <= 1'b0;
            done_q       <= 1'b0;
`ifdef VT52_SCROLL_DOWN_EN
            down_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            copy_end_q   <= copy_end_d;
            fill_start_q <= fill_start_d;
            fill_end_q   <= fill_end_d;
            odd_q        <= odd_d;
            done_q       <= done_d;
`ifdef VT52_SCROLL_DOWN_EN
            down_q       <= down_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;

    vt52_wb_access u_acc (
        .clk_i       (wb_clk_i),
        .rst_n_i     (wb_rst_n_i),
        .req_i       (acc_req),
        .we_i        (acc_we),
        .adr_i       (acc_adr),
        .dat_i       (acc_dat),
        .sel_i       (acc_sel),
        .busy_o      (acc_busy),
        .rdata_o     (acc_rdata),
        .ack_pulse_o (acc_ack),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i)
    );

endmodule

// File: tb/tb_vt52_scroll_engine.sv
// Bench for vt52_scroll_engine: memory-model Wishbone slave with programmable ack delay,
// expected bus transactions queued per command and checked at each slave ack.
// Directed sequence: reset, scroll up, EOS/EOL clears, out-of-range, scroll down, reset mid-op.
module tb_vt52_scroll_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lmode = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [12:0] cmd_pos = 13'd0;
    logic        done;
    logic [15:0] adr, dat_o;
    logic [15:0] dat_i = 16'h0000;
    logic        cyc, stb, we;
    logic        ack = 1'b0;
    logic [1:0]  sel;

    always #5 clk = ~clk;

    vt52_scroll_engine dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .lmode      (lmode),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_pos    (cmd_pos),
        .done       (done),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_dat_i  (dat_i),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_ack_i  (ack)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  sel;
        logic [15:0] adr;
        logic [15:0] dat;
    } txn_t;

    txn_t        sb[$];
    logic [15:0] mem   [0:4095];
    logic [15:0] ref_m [0:4095];

    int n_vec = 0, n_err = 0;
    int ack_delay = 0, dcnt = 0;
    int n_rd = 0, n_wr = 0, wr_starts = 0, cyc_cycles = 0, done_cnt = 0;
    bit sb_en = 1'b1;
    logic prev_cyc = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic w, input logic [1:0] s, input int a, input logic [15:0] d);
        txn_t t;
        t.we  = w;
        t.sel = s;
        t.adr = 16'(a);
        t.dat = w ? d : 16'h0000;
        sb.push_back(t);
    endfunction

    // Slave memory + monitor: one-cycle ack after ack_delay cycles, never re-acked while ack is high.
    always @(negedge clk) begin
        txn_t o, e;
        if (done) done_cnt++;
        if (cyc) cyc_cycles++;
        if (cyc && we && !prev_cyc) wr_starts++;
        prev_cyc = cyc;
        if (!rst_n) begin
            ack  = 1'b0;
            dcnt = 0;
        end else if (ack) begin
            ack = 1'b0;
        end else if (cyc && stb) begin
            if (dcnt >= ack_delay) begin
                dcnt  = 0;
                ack   = 1'b1;
                o.we  = we;
                o.sel = sel;
                o.adr = adr;
                o.dat = we ? dat_o : 16'h0000;
                if (we) begin
                    n_wr++;
                    if (sel[0]) mem[adr[12:1]][7:0]  = dat_o[7:0];
                    if (sel[1]) mem[adr[12:1]][15:8] = dat_o[15:8];
                end else begin
                    n_rd++;
                    dat_i = mem[adr[12:1]];
                end
                if (sb_en) begin
                    if (sb.size() == 0) begin
                        check("unexpected_txn", 64'(o), 64'h0);
                    end else begin
                        e = sb.pop_front();
                        check("bus_txn", 64'(o), 64'(e));
                    end
                end
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [12:0] pos, input logic lm);
        @(negedge clk);
        cmd_op    = op;
        cmd_pos   = pos;
        lmode     = lm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until done is seen (bounded).
    task automatic wait_done(input int budget, input string tag, output int cycles);
        logic found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) found = 1'b1;
        end
        check(tag, 64'(found), 64'h1);
    endtask

    task automatic preload();
        for (int w = 0; w < 4096; w++) begin
            int row;
            row    = (w * 2) / 80;
            mem[w] = 16'(32'h4241 + (row - 2) * 32'h0202);
        end
    endtask

    function automatic int mem_diffs();
        int n;
        n = 0;
        for (int w = 0; w < 4096; w++) if (mem[w] !== ref_m[w]) n++;
        return n;
    endfunction

    initial begin
        int cyc_n, wr0;
        int cnt20;
        logic [15:0] snap122, snap160, snap_r22;

        preload();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check("rst_done",      64'(done),      64'h0);
        check("rst_cyc",       64'(cyc),       64'h0);
        check("rst_stb",       64'(stb),       64'h0);
        check("rst_we",        64'(we),        64'h0);
        check("rst_sel",       64'(sel),       64'h3);
        check("rst_adr",       64'(adr),       64'h0);
        check("rst_dat",       64'(dat_o),     64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scroll up, 24-row mode
        for (int w = 0; w < 4096; w++) ref_m[w] = mem[w];
        for (int p = 160; p <= 1838; p += 2) begin
            push(1'b0, 2'b11, p + 80, 16'h0);
            push(1'b1, 2'b11, p, ref_m[(p + 80) / 2]);
            ref_m[p / 2] = ref_m[(p + 80) / 2];
        end
        for (int p = 1840; p <= 1918; p += 2) begin
            push(1'b1, 2'b11, p, 16'h2020);
            ref_m[p / 2] = 16'h2020;
        end
        n_rd = 0; n_wr = 0; done_cnt = 0;
        issue(2'd0, 13'd0, 1'b0);
        wait_done(20000, "up_done_seen", cyc_n);
        repeat (4) @(negedge clk);
        check("up_sb_empty",  64'(sb.size()), 64'h0);
        check("up_reads",     64'(n_rd), 64'd840);
        check("up_writes",    64'(n_wr), 64'd880);
        check("up_word160",   64'(mem[80]), 64'h4443);
        cnt20 = 0;
        for (int w = 920; w < 960; w++) if (mem[w] === 16'h2020) cnt20++;
        check("up_row23_fill", 64'(cnt20), 64'd40);
        check("up_done_once",  64'(done_cnt), 64'd1);
        check("up_mem_diffs",  64'(mem_diffs()), 64'd0);
        sb.delete();

        // Clear to end of screen from the very last byte, 40-row mode
        push(1'b1, 2'b10, 3198, 16'h2020);
        wr0 = n_wr;
        issue(2'd3, 13'd3199, 1'b1);
        wait_done(200, "eos_done_seen", cyc_n);
        check("eos_sb_empty", 64'(sb.size()), 64'h0);
        check("eos_writes",   64'(n_wr - wr0), 64'd1);
        sb.delete();

        // Clear to end of line from odd position in row 3
        snap122 = mem[122];
        snap160 = mem[160];
        push(1'b1, 2'b10, 244, 16'h2020);
        for (int p = 246; p <= 318; p += 2) push(1'b1, 2'b11, p, 16'h2020);
        issue(2'd2, 13'd245, 1'b0);
        wait_done(2000, "eol_done_seen", cyc_n);
        check("eol_sb_empty",  64'(sb.size()), 64'h0);
        check("eol_byte244",   64'(mem[122][7:0]), 64'(snap122[7:0]));
        check("eol_byte245",   64'(mem[122][15:8]), 64'h20);
        check("eol_word320",   64'(mem[160]), 64'(snap160));
        sb.delete();

        // Service-row position: no traffic, done two cycles after accept
        cyc_cycles = 0;
        issue(2'd3, 13'd100, 1'b0);
        wait_done(50, "oor_done_seen", cyc_n);
        check("oor_done_latency", 64'(cyc_n), 64'd2);
        check("oor_no_cyc",       64'(cyc_cycles), 64'd0);

        // Scroll down, 24-row mode
        snap_r22 = mem[880];
`ifdef VT52_SCROLL_DOWN_EN
        for (int w = 0; w < 4096; w++) ref_m[w] = mem[w];
        for (int p = 1838; p >= 160; p -= 2) begin
            push(1'b0, 2'b11, p, 16'h0);
            push(1'b1, 2'b11, p + 80, ref_m[p / 2]);
            ref_m[(p + 80) / 2] = ref_m[p / 2];
        end
        for (int p = 160; p <= 238; p += 2) begin
            push(1'b1, 2'b11, p, 16'h2020);
            ref_m[p / 2] = 16'h2020;
        end
        issue(2'd1, 13'd0, 1'b0);
        wait_done(20000, "dn_done_seen", cyc_n);
        check("dn_sb_empty",  64'(sb.size()), 64'h0);
        check("dn_row23",     64'(mem[920]), 64'(snap_r22));
        check("dn_row2_fill", 64'(mem[80]), 64'h2020);
        check("dn_mem_diffs", 64'(mem_diffs()), 64'd0);
        sb.delete();
`else
        cyc_cycles = 0;
        issue(2'd1, 13'd0, 1'b0);
        wait_done(50, "dn_done_seen", cyc_n);
        check("dn_done_latency", 64'(cyc_n), 64'd2);
        check("dn_no_cyc",       64'(cyc_cycles), 64'd0);
        check("dn_row23_kept",   64'(mem[920]), 64'h2020);
        check("dn_row22_kept",   64'(mem[880]), 64'(snap_r22));
`endif

        // Slow slave, reset asserted during the third write
        sb_en     = 1'b0;
        ack_delay = 5;
        wr_starts = 0;
        issue(2'd0, 13'd0, 1'b0);
        cyc_n = 0;
        while (wr_starts < 3 && cyc_n < 2000) begin
            @(negedge clk);
            cyc_n++;
        end
        check("mid_third_write_seen", 64'(wr_starts >= 3), 64'h1);
        check("mid_cyc_before_rst",   64'(cyc), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 64'(cyc), 64'h0);
        check("mid_rst_stb", 64'(stb), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 64'h1);
        check("post_rst_done",  64'(done), 64'h0);
        check("post_rst_cyc",   64'(cyc), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
